// File: rtl/xnor_diff_pkg.sv
// Shared definitions for the XNOR-differential serial link (receiver and transmitter).
//   rx_state_e  : receiver frame FSM states
//   rx_err_t    : per-frame error/status pulse bundle
//   START_BIT / STOP_BIT : decoded framing bit values
//   even_parity : parity helper, payload zero-extended to MAX_DATA_W
package xnor_diff_pkg;

    localparam int unsigned MAX_DATA_W = 16;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic frame_err;
        logic par_err;
        logic overrun;
    } rx_err_t;

    // Even parity: the parity bit equals the XOR of all payload bits.
    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/xnor_diff_bitdec.sv
// XNOR-differential line decoder.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   line_in    : encoded serial bit
//   line_valid : line_in is meaningful this cycle
//   dec        : decoded bit ~(line_in ^ prev), combinational
//   dec_valid  : dec is meaningful this cycle, combinational
// dec/dec_valid are combinational so the frame FSM sees each bit in the
// cycle it is sampled; prev only advances on valid samples.
module xnor_diff_bitdec #(
    parameter logic PREV_INIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    input  logic line_valid,
    output logic dec,
    output logic dec_valid
);

    logic prev;

    // Previous line level, held across invalid cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= PREV_INIT;
        end else if (line_valid) begin
            prev <= line_in;
        end
    end

    assign dec       = ~(line_in ^ prev);
    assign dec_valid = line_valid;

endmodule

// File: rtl/xnor_diff_rx.sv
// XNOR-differential serial frame receiver.
// Frame (decoded): start(0), DATA_W payload bits LSB first, [even parity], stop(1).
// Build option: define XNOR_DIFF_RX_PARITY_EN to include the parity bit/state;
// otherwise frames carry no parity bit and par_err stays 0.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   line_in    : encoded serial bit, sampled when line_valid=1
//   line_valid : sample qualifier
//   out_ready  : downstream accepts out_data
//   out_data   : decoded payload (registered)
//   out_valid  : out_data holds an unconsumed frame
//   frame_err  : one-cycle pulse, bad stop bit
//   par_err    : one-cycle pulse, parity mismatch
//   overrun    : one-cycle pulse, good frame dropped because output was full
//   busy       : FSM is not IDLE
module xnor_diff_rx
    import xnor_diff_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter logic        PREV_INIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_in,
    input  logic              line_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              frame_err,
    output logic              par_err,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned       CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    logic              dec;
    logic              dec_valid;

    rx_state_e         state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [DATA_W-1:0] shreg_q,   shreg_d;
    logic              par_bad_q, par_bad_d;
    logic [DATA_W-1:0] out_data_d;
    logic              out_valid_d;
    logic              busy_d;
    rx_err_t           err_d;

    xnor_diff_bitdec #(
        .PREV_INIT (PREV_INIT)
    ) u_bitdec (
        .clk        (clk),
        .rst        (rst),
        .line_in    (line_in),
        .line_valid (line_valid),
        .dec        (dec),
        .dec_valid  (dec_valid)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            par_bad_q <= par_bad_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            frame_err <= err_d.frame_err;
            par_err   <= err_d.par_err;
            overrun   <= err_d.overrun;
            busy      <= busy_d;
        end
    end

    // Frame FSM: advances only on valid decoded bits.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        par_bad_d   = par_bad_q;
        out_data_d  = out_data;
        out_valid_d = out_valid & ~out_ready;
        err_d       = '0;

        if (dec_valid) begin
            case (state_q)
                IDLE: begin
                    if (dec == START_BIT) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        par_bad_d = 1'b0;
                    end
                end
                DATA: begin
                    shreg_d = {dec, shreg_q[DATA_W-1:1]};
                    if (cnt_q == LAST_BIT) begin
                        cnt_d = '0;
`ifdef XNOR_DIFF_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef XNOR_DIFF_RX_PARITY_EN
                PARITY: begin
                    par_bad_d = (dec != even_parity(MAX_DATA_W'(shreg_q)));
                    state_d   = STOP;
                end
`endif
                STOP: begin
                    state_d = IDLE;
                    if (dec != STOP_BIT) begin
                        err_d.frame_err = 1'b1;
                    end else if (par_bad_q) begin
                        err_d.par_err = 1'b1;
                    end else if (!out_valid || out_ready) begin
                        // Slot is free or being drained this cycle.
                        out_data_d  = shreg_q;
                        out_valid_d = 1'b1;
                    end else begin
                        err_d.overrun = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_xnor_diff_rx.sv
// Self-checking bench for xnor_diff_rx: encodes decoded frames onto the line,
// queues the expected outputs/pulses and compares them as the DUT emits them.
module tb_xnor_diff_rx;

    localparam int unsigned DATA_W = 8;

    localparam logic [31:0] E_FERR = 32'h4;
    localparam logic [31:0] E_PERR = 32'h2;
    localparam logic [31:0] E_OVR  = 32'h1;

    localparam int K_OUT  = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;
    localparam int K_OVR  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              line_in;
    logic              line_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              frame_err;
    logic              par_err;
    logic              overrun;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic        tx_prev;
    logic [31:0] out_q[$];
    logic [31:0] err_q[$];

    logic              hold_pend = 1'b0;
    logic [DATA_W-1:0] hold_data = '0;

    always #5 clk = ~clk;

    xnor_diff_rx #(
        .DATA_W    (DATA_W),
        .PREV_INIT (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .line_in    (line_in),
        .line_valid (line_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .frame_err  (frame_err),
        .par_err    (par_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one decoded bit as an XNOR-encoded line level, optionally followed by an invalid cycle.
    task automatic put_bit(input logic d, input bit toggle);
        @(posedge clk); #1;
        line_valid = 1'b1;
        line_in    = d ? tx_prev : ~tx_prev;
        tx_prev    = line_in;
        if (toggle) begin
            @(posedge clk); #1;
            line_valid = 1'b0;
            line_in    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] data, input logic stop_d,
                              input bit par_flip, input bit toggle, input int kind);
        case (kind)
            K_OUT:   out_q.push_back(32'(data));
            K_FERR:  err_q.push_back(E_FERR);
            K_PERR:  err_q.push_back(E_PERR);
            default: err_q.push_back(E_OVR);
        endcase
        put_bit(1'b0, toggle);
        for (int i = 0; i < int'(DATA_W); i++) put_bit(data[i], toggle);
`ifdef XNOR_DIFF_RX_PARITY_EN
        put_bit((^data) ^ par_flip, toggle);
`endif
        put_bit(stop_d, toggle);
        if (!toggle) begin
            @(posedge clk); #1;
            line_valid = 1'b0;
        end
        // Stop bit has been sampled; its result is due now.
        @(negedge clk);
        case (kind)
            K_OUT: begin
                check("lat_valid", 32'(out_valid), 32'd1);
                check("lat_data", 32'(out_data), 32'(data));
            end
            K_FERR:  check("ferr_pulse", 32'(frame_err), 32'd1);
            K_PERR:  check("perr_pulse", 32'(par_err), 32'd1);
            default: check("ovr_pulse", 32'(overrun), 32'd1);
        endcase
        if (kind != K_OUT && kind != K_OVR) check("err_noload", 32'(out_valid), 32'd0);
    endtask

    // Scoreboard monitor: consumes queued expectations as the DUT produces them.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) check("hold", 32'({out_valid, out_data}), 32'({1'b1, hold_data}));
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            if (out_valid && out_ready)
                check("out_data", 32'(out_data),
                      (out_q.size() != 0) ? out_q.pop_front() : 32'hFFFF_FFFF);
            if (frame_err || par_err || overrun)
                check("err_pulse", 32'({frame_err, par_err, overrun}),
                      (err_q.size() != 0) ? err_q.pop_front() : 32'hFF);
        end
    end

    initial begin
        rst        = 1'b1;
        line_in    = 1'b0;
        line_valid = 1'b0;
        out_ready  = 1'b1;
        tx_prev    = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_errs", 32'({frame_err, par_err, overrun}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle marks (decoded 1) keep the FSM in IDLE.
        repeat (3) put_bit(1'b1, 1'b0);
        @(posedge clk); #1;
        line_valid = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic frame, then the same frame with line_valid toggling.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, K_OUT);
        @(negedge clk);
        check("one_cycle_valid", 32'(out_valid), 32'd0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, K_OUT);

        // Bad stop bit, then a good frame.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, K_FERR);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, K_OUT);

`ifdef XNOR_DIFF_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, K_PERR);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, K_OUT);
`endif

        // Back-pressure: first frame held, second dropped with overrun.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, K_OUT);
        send_frame(8'hAA, 1'b1, 1'b0, 1'b0, K_OVR);
        check("ovr_retain", 32'(out_data), 32'h55);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("drain_drop", 32'(out_valid), 32'd0);

        // Reset mid-frame: start + 4 data bits of 0xFF, then reset.
        put_bit(1'b0, 1'b0);
        repeat (4) put_bit(1'b1, 1'b0);
        @(posedge clk); #1;
        line_valid = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst     = 1'b1;
        tx_prev = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out", 32'({out_valid, frame_err, par_err, overrun}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, K_OUT);

        // Random payloads and pacing.
        for (int n = 0; n < 6; n++) begin
            send_frame(DATA_W'($urandom_range(0, 255)), 1'b1, 1'b0,
                       1'($urandom_range(0, 1)), K_OUT);
        end

        repeat (5) @(negedge clk);
        check("out_q_left", 32'(out_q.size()), 32'd0);
        check("err_q_left", 32'(err_q.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
